// File: rtl/lke_tcam_pipe.sv
// ---------------------------------------------------------------------------
// lke_tcam_pipe
//
// Ternary lookup engine between the key extractor and the action engine.
// The extracted key is compared against DEPTH register-based entries
// (key, mask, valid). The lowest matching index wins. A hit returns that
// entry's action and a miss returns the programmable default action. The PHV
// travels alongside the key through a two-stage valid/ready pipeline.
// Per-entry hit counters and a single miss counter can be read through a
// registered side port.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   extract_key           lookup key
//   key_valid, phv_valid  input beat qualifiers (beat = key_valid & phv_valid)
//   phv_in                PHV carried with the key
//   ready_out             upstream may present a beat this cycle
//   action, action_valid  looked-up action and output beat valid
//   phv_out               PHV aligned with action
//   match_addr, if_match  winning entry index (0 on miss) and hit flag
//   ready_in              downstream ready
//   cfg_ent_we            write key/mask/valid at cfg_addr (clears its hit counter)
//   cfg_act_we            write action at cfg_addr
//   cfg_def_we            write default (miss) action from cfg_act
//   cfg_addr, cfg_key, cfg_mask, cfg_ent_vld, cfg_act   configuration data
//   cnt_rd_addr           MSB set selects the miss counter, else hit counter[addr]
//   cnt_rd_data           selected counter, one cycle after the address
// ---------------------------------------------------------------------------
module lke_tcam_pipe #(
    parameter int PHV_LEN = 2304,
    parameter int KEY_LEN = 257,
    parameter int ACT_LEN = 625,
    parameter int ADDR_W  = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_LEN-1:0] extract_key,
    input  logic               key_valid,
    input  logic               phv_valid,
    input  logic [PHV_LEN-1:0] phv_in,
    output logic               ready_out,
    output logic [ACT_LEN-1:0] action,
    output logic               action_valid,
    output logic [PHV_LEN-1:0] phv_out,
    output logic [ADDR_W-1:0]  match_addr,
    output logic               if_match,
    input  logic               ready_in,
    input  logic               cfg_ent_we,
    input  logic               cfg_act_we,
    input  logic               cfg_def_we,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [KEY_LEN-1:0] cfg_key,
    input  logic [KEY_LEN-1:0] cfg_mask,
    input  logic               cfg_ent_vld,
    input  logic [ACT_LEN-1:0] cfg_act,
    input  logic [ADDR_W:0]    cnt_rd_addr,
    output logic [CNT_W-1:0]   cnt_rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Entry table
    logic [DEPTH-1:0]   ent_vld;
    logic [KEY_LEN-1:0] ent_key  [DEPTH];
    logic [KEY_LEN-1:0] ent_mask [DEPTH];
    logic [ACT_LEN-1:0] ent_act  [DEPTH];
    logic [ACT_LEN-1:0] def_act;

    // Statistics
    logic [CNT_W-1:0]   hit_cnt  [DEPTH];
    logic [CNT_W-1:0]   miss_cnt;

    // Pipeline state
    logic               in_valid;
    logic               adv1;
    logic               adv2;
    logic               s1_valid;
    logic [DEPTH-1:0]   s1_vec;
    logic [PHV_LEN-1:0] s1_phv;
    logic               s2_valid;

    logic [DEPTH-1:0]   match_vec;
    logic [ADDR_W-1:0]  win_addr;
    logic               win_hit;
    logic               cnt_en;

    // -----------------------------------------------------------------------
    // Handshake: a beat moves across a boundary on an edge where the sender
    // holds valid and the receiver holds ready. A stage may load when it is
    // empty or when its own content leaves in the same cycle, so
    //   adv2 = ~s2_valid | ready_in, adv1 = ~s1_valid | adv2, ready_out = adv1.
    // Valid never depends on ready; stage-2 outputs stay frozen while
    // action_valid is high and ready_in is low. ready_out is forced low while
    // reset is asserted so upstream sees no opening during reset.
    // -----------------------------------------------------------------------
    assign in_valid     = key_valid & phv_valid;
    assign adv2         = ~s2_valid | ready_in;
    assign adv1         = ~s1_valid | adv2;
    assign ready_out    = rst_n & adv1;
    assign action_valid = s2_valid;

    // An entry hits when every unmasked bit agrees with the key.
    always_comb begin
        match_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_vec[i] = ent_vld[i] &&
                           (((extract_key ^ ent_key[i]) & ~ent_mask[i]) == '0);
        end
    end

    // Lowest set bit wins: scanning downwards lets the lowest index overwrite.
    always_comb begin
        win_addr = '0;
        win_hit  = |s1_vec;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (s1_vec[i]) begin
                win_addr = ADDR_W'(i);
            end
        end
    end

    // A counter event happens only when a real beat enters stage 2.
    assign cnt_en = adv2 & s1_valid;

    // -----------------------------------------------------------------------
    // Configuration table. Stage 2 reads ent_act combinationally before this
    // edge's write lands, so a same-edge action write is seen by later beats.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_vld <= '0;
            def_act <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_key[i]  <= '0;
                ent_mask[i] <= '0;
                ent_act[i]  <= '0;
            end
        end else begin
            if (cfg_ent_we) begin
                ent_vld[cfg_addr]  <= cfg_ent_vld;
                ent_key[cfg_addr]  <= cfg_key;
                ent_mask[cfg_addr] <= cfg_mask;
            end
            if (cfg_act_we) begin
                ent_act[cfg_addr] <= cfg_act;
            end
            if (cfg_def_we) begin
                def_act <= cfg_act;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Two-stage pipeline. Stage 1 holds the match vector and PHV; stage 2
    // resolves the winner and the action.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_vec     <= '0;
            s1_phv     <= '0;
            s2_valid   <= 1'b0;
            action     <= '0;
            phv_out    <= '0;
            match_addr <= '0;
            if_match   <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid <= in_valid;
                s1_vec   <= match_vec;
                s1_phv   <= phv_in;
            end
            if (adv2) begin
                s2_valid   <= s1_valid;
                action     <= win_hit ? ent_act[win_addr] : def_act;
                phv_out    <= s1_phv;
                match_addr <= win_addr;
                if_match   <= win_hit;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Counters. Rewriting an entry restarts its statistics, which takes
    // priority over a same-cycle hit on that entry. All counters saturate.
    // The read port samples the pre-increment value.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_cnt    <= '0;
            cnt_rd_data <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                hit_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cfg_ent_we && (cfg_addr == ADDR_W'(i))) begin
                    hit_cnt[i] <= '0;
                end else if (cnt_en && win_hit && (win_addr == ADDR_W'(i)) &&
                             (hit_cnt[i] != '1)) begin
                    hit_cnt[i] <= hit_cnt[i] + CNT_W'(1);
                end
            end
            if (cnt_en && !win_hit && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + CNT_W'(1);
            end
            cnt_rd_data <= cnt_rd_addr[ADDR_W] ? miss_cnt
                                               : hit_cnt[cnt_rd_addr[ADDR_W-1:0]];
        end
    end

endmodule

// File: tb/tb_lke_tcam_pipe.sv
// ---------------------------------------------------------------------------
// tb_lke_tcam_pipe
//
// Directed bench for lke_tcam_pipe. A second instance built with CNT_W=4
// shares every input with the main instance and exercises saturation.
// Inputs change and outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_lke_tcam_pipe;

    localparam int PHV_LEN = 2304;
    localparam int KEY_LEN = 257;
    localparam int ACT_LEN = 625;
    localparam int ADDR_W  = 4;
    localparam int CNT_W   = 32;

    localparam logic [ACT_LEN-1:0] ACT_A3 = ACT_LEN'(32'hA3);
    localparam logic [ACT_LEN-1:0] ACT_E3 = ACT_LEN'(32'hE3);
    localparam logic [ACT_LEN-1:0] ACT_B1 = ACT_LEN'(32'hB1);
    localparam logic [ACT_LEN-1:0] ACT_B5 = ACT_LEN'(32'hB5);
    localparam logic [ACT_LEN-1:0] ACT_DD = ACT_LEN'(32'hDD);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [KEY_LEN-1:0] extract_key;
    logic               key_valid;
    logic               phv_valid;
    logic [PHV_LEN-1:0] phv_in;
    logic               ready_out;
    logic [ACT_LEN-1:0] action;
    logic               action_valid;
    logic [PHV_LEN-1:0] phv_out;
    logic [ADDR_W-1:0]  match_addr;
    logic               if_match;
    logic               ready_in;
    logic               cfg_ent_we;
    logic               cfg_act_we;
    logic               cfg_def_we;
    logic [ADDR_W-1:0]  cfg_addr;
    logic [KEY_LEN-1:0] cfg_key;
    logic [KEY_LEN-1:0] cfg_mask;
    logic               cfg_ent_vld;
    logic [ACT_LEN-1:0] cfg_act;
    logic [ADDR_W:0]    cnt_rd_addr;
    logic [CNT_W-1:0]   cnt_rd_data;

    logic               sm_ready_out;
    logic [ACT_LEN-1:0] sm_action;
    logic               sm_action_valid;
    logic [PHV_LEN-1:0] sm_phv_out;
    logic [ADDR_W-1:0]  sm_match_addr;
    logic               sm_if_match;
    logic [3:0]         sm_cnt_rd_data;

    int checks   = 0;
    int failures = 0;

    lke_tcam_pipe #(
        .PHV_LEN(PHV_LEN), .KEY_LEN(KEY_LEN), .ACT_LEN(ACT_LEN),
        .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .extract_key(extract_key), .key_valid(key_valid), .phv_valid(phv_valid),
        .phv_in(phv_in), .ready_out(ready_out), .action(action),
        .action_valid(action_valid), .phv_out(phv_out), .match_addr(match_addr),
        .if_match(if_match), .ready_in(ready_in),
        .cfg_ent_we(cfg_ent_we), .cfg_act_we(cfg_act_we), .cfg_def_we(cfg_def_we),
        .cfg_addr(cfg_addr), .cfg_key(cfg_key), .cfg_mask(cfg_mask),
        .cfg_ent_vld(cfg_ent_vld), .cfg_act(cfg_act),
        .cnt_rd_addr(cnt_rd_addr), .cnt_rd_data(cnt_rd_data)
    );

    lke_tcam_pipe #(
        .PHV_LEN(PHV_LEN), .KEY_LEN(KEY_LEN), .ACT_LEN(ACT_LEN),
        .ADDR_W(ADDR_W), .CNT_W(4)
    ) u_small (
        .clk(clk), .rst_n(rst_n),
        .extract_key(extract_key), .key_valid(key_valid), .phv_valid(phv_valid),
        .phv_in(phv_in), .ready_out(sm_ready_out), .action(sm_action),
        .action_valid(sm_action_valid), .phv_out(sm_phv_out),
        .match_addr(sm_match_addr), .if_match(sm_if_match), .ready_in(ready_in),
        .cfg_ent_we(cfg_ent_we), .cfg_act_we(cfg_act_we), .cfg_def_we(cfg_def_we),
        .cfg_addr(cfg_addr), .cfg_key(cfg_key), .cfg_mask(cfg_mask),
        .cfg_ent_vld(cfg_ent_vld), .cfg_act(cfg_act),
        .cnt_rd_addr(cnt_rd_addr), .cnt_rd_data(sm_cnt_rd_data)
    );

    // ---------------- stimulus helpers ----------------
    function automatic logic [PHV_LEN-1:0] mk_phv(input int t);
        logic [PHV_LEN-1:0] v;
        v = '0;
        v[31:0]             = t;
        v[1000 +: 32]       = t * 3 + 7;
        v[PHV_LEN-1 -: 32]  = ~t;
        return v;
    endfunction

    task automatic cfg_entry(input int addr, input int key, input bit mask_all,
                             input bit vld, input int act);
        cfg_ent_we  = 1'b1;
        cfg_act_we  = 1'b1;
        cfg_addr    = addr[ADDR_W-1:0];
        cfg_key     = KEY_LEN'(key);
        cfg_mask    = mask_all ? '1 : '0;
        cfg_ent_vld = vld;
        cfg_act     = ACT_LEN'(act);
        @(posedge clk); #1;
        cfg_ent_we  = 1'b0;
        cfg_act_we  = 1'b0;
    endtask

    task automatic cfg_default(input int act);
        cfg_def_we = 1'b1;
        cfg_act    = ACT_LEN'(act);
        @(posedge clk); #1;
        cfg_def_we = 1'b0;
    endtask

    task automatic drive_beat(input bit v, input int key, input int tag);
        key_valid   = v;
        phv_valid   = v;
        extract_key = KEY_LEN'(key);
        phv_in      = mk_phv(tag);
    endtask

    // One beat with ready_in=1; returns when the beat sits on the outputs.
    task automatic beat2(input int key, input int tag);
        drive_beat(1'b1, key, tag);
        @(posedge clk); #1;
        drive_beat(1'b0, 0, 0);
        @(posedge clk); #1;
    endtask

    task automatic read_cnt(input logic [ADDR_W:0] a);
        cnt_rd_addr = a;
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive_beat(1'b0, 0, 0);
        ready_in = 1'b0; cfg_ent_we = 1'b0; cfg_act_we = 1'b0; cfg_def_we = 1'b0;
        cfg_addr = '0; cfg_key = '0; cfg_mask = '0; cfg_ent_vld = 1'b0;
        cfg_act = '0; cnt_rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ready_out !== 1'b0) begin failures++; $display("FAIL rst_ready_out got=%b exp=0", ready_out); end
        checks++; if (sm_ready_out !== 1'b0) begin failures++; $display("FAIL rst_sm_ready_out got=%b exp=0", sm_ready_out); end
        checks++; if (action_valid !== 1'b0) begin failures++; $display("FAIL rst_action_valid got=%b exp=0", action_valid); end
        checks++; if (action !== '0) begin failures++; $display("FAIL rst_action got=%h exp=0", action); end
        checks++; if (phv_out !== '0) begin failures++; $display("FAIL rst_phv_out got_lo=%h exp=0", phv_out[31:0]); end
        checks++; if (match_addr !== '0 || if_match !== 1'b0) begin failures++; $display("FAIL rst_match got=%0d/%b exp=0/0", match_addr, if_match); end
        checks++; if (cnt_rd_data !== '0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", cnt_rd_data); end
        #2 rst_n = 1'b1;
        #1;
        checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL rel_ready_out got=%b exp=1", ready_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        cfg_entry(3, 'h5A, 1'b0, 1'b1, 'hA3);
        cfg_default('hDD);
        ready_in = 1'b1;
        drive_beat(1'b1, 'h5A, 1);
        @(posedge clk); #1;
        drive_beat(1'b0, 0, 0);
        checks++; if (action_valid !== 1'b0) begin failures++; $display("FAIL basic_latency1 got=%b exp=0", action_valid); end
        @(posedge clk); #1;
        checks++; if (action_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", action_valid); end
        checks++; if (action !== ACT_A3) begin failures++; $display("FAIL basic_action got=%h exp=a3", action); end
        checks++; if (match_addr !== 4'd3 || if_match !== 1'b1) begin failures++; $display("FAIL basic_match got=%0d/%b exp=3/1", match_addr, if_match); end
        checks++; if (phv_out !== mk_phv(1)) begin failures++; $display("FAIL basic_phv got_lo=%h exp_lo=%h", phv_out[31:0], 32'd1); end
    endtask

    task automatic test_priority();
        cfg_entry(1, 'h11, 1'b0, 1'b1, 'hB1);
        cfg_entry(5, 'h77, 1'b1, 1'b1, 'hB5);
        beat2('h11, 10);
        checks++; if (match_addr !== 4'd1 || action !== ACT_B1) begin failures++; $display("FAIL prio_low got=%0d/%h exp=1/b1", match_addr, action); end
        cfg_entry(1, 'h11, 1'b0, 1'b0, 'hB1);
        beat2('h11, 11);
        checks++; if (match_addr !== 4'd5 || action !== ACT_B5 || if_match !== 1'b1) begin failures++; $display("FAIL prio_wild got=%0d/%h/%b exp=5/b5/1", match_addr, action, if_match); end
        cfg_entry(5, 'h77, 1'b1, 1'b0, 'hB5);
        beat2('h00, 12);
        checks++; if (action !== ACT_DD || if_match !== 1'b0 || match_addr !== 4'd0) begin failures++; $display("FAIL prio_miss got=%h/%b/%0d exp=dd/0/0", action, if_match, match_addr); end
        checks++; if (action_valid !== 1'b1) begin failures++; $display("FAIL prio_miss_valid got=%b exp=1", action_valid); end
        read_cnt(5'h10);
        checks++; if (cnt_rd_data !== 32'd1) begin failures++; $display("FAIL miss_cnt got=%0d exp=1", cnt_rd_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        logic [ACT_LEN-1:0] a_hold;
        ready_in = 1'b0;
        drive_beat(1'b1, 'h5A, 100);
        #1;
        checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL stall_empty_ready got=%b exp=1", ready_out); end
        @(posedge clk); #1;
        drive_beat(1'b1, 'h5A, 101);
        @(posedge clk); #1;
        drive_beat(1'b1, 'h5A, 102);
        checks++; if (ready_out !== 1'b0) begin failures++; $display("FAIL stall_full_ready got=%b exp=0", ready_out); end
        checks++; if (action_valid !== 1'b1 || phv_out !== mk_phv(100) || action !== ACT_A3) begin failures++; $display("FAIL stall_head got=%b/%h exp=1/%h", action_valid, phv_out[31:0], 32'd100); end
        a_hold = action;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++; if (phv_out !== mk_phv(100) || action !== a_hold || action_valid !== 1'b1) begin failures++; $display("FAIL stall_hold%0d got=%b/%h exp=1/%h", k, action_valid, phv_out[31:0], 32'd100); end
            checks++; if (ready_out !== 1'b0) begin failures++; $display("FAIL stall_hold_ready%0d got=%b exp=0", k, ready_out); end
        end
        ready_in = 1'b1;
        #1;
        checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL stall_release_ready got=%b exp=1", ready_out); end
        @(posedge clk); #1;
        drive_beat(1'b0, 0, 0);
        checks++; if (action_valid !== 1'b1 || phv_out !== mk_phv(101)) begin failures++; $display("FAIL stall_drain1 got=%b/%h exp=1/%h", action_valid, phv_out[31:0], 32'd101); end
        @(posedge clk); #1;
        checks++; if (action_valid !== 1'b1 || phv_out !== mk_phv(102)) begin failures++; $display("FAIL stall_drain2 got=%b/%h exp=1/%h", action_valid, phv_out[31:0], 32'd102); end
        @(posedge clk); #1;
        checks++; if (action_valid !== 1'b0) begin failures++; $display("FAIL stall_empty got=%b exp=0", action_valid); end
    endtask

    task automatic test_backpressure();
        logic [PHV_LEN-1:0] exp_q[$];
        logic [PHV_LEN-1:0] hold_phv;
        logic               pat [4];
        logic               acc;
        logic               xfer;
        logic               was_stalled;
        int idx, rcv, cyc;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        idx = 0; rcv = 0; cyc = 0; was_stalled = 1'b0; hold_phv = '0;
        while (rcv < 8 && cyc < 100) begin
            ready_in = pat[cyc % 4];
            drive_beat(idx < 8, 'h5A, 200 + idx);
            #1;
            if (was_stalled) begin
                checks++; if (action_valid !== 1'b1 || phv_out !== hold_phv) begin failures++; $display("FAIL bp_stable cyc=%0d got=%b/%h exp=1/%h", cyc, action_valid, phv_out[31:0], hold_phv[31:0]); end
            end
            acc  = key_valid & phv_valid & ready_out;
            xfer = action_valid & ready_in;
            was_stalled = action_valid & ~ready_in;
            hold_phv    = phv_out;
            if (xfer) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL bp_extra got_lo=%h exp=none", phv_out[31:0]);
                end else begin
                    checks++; if (phv_out !== exp_q[0] || action !== ACT_A3) begin failures++; $display("FAIL bp_order rcv=%0d got_lo=%h exp_lo=%h", rcv, phv_out[31:0], exp_q[0][31:0]); end
                    void'(exp_q.pop_front());
                end
                rcv++;
            end
            @(posedge clk); #1;
            if (acc) begin
                exp_q.push_back(mk_phv(200 + idx));
                idx++;
            end
            cyc++;
        end
        drive_beat(1'b0, 0, 0);
        ready_in = 1'b1;
        checks++; if (rcv != 8 || idx != 8) begin failures++; $display("FAIL bp_count got=%0d/%0d exp=8/8", rcv, idx); end
        @(posedge clk); #1;
        checks++; if (action_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", action_valid); end
    endtask

    task automatic run_hits(input int n);
        int nv;
        int low;
        nv = 0; low = 0;
        ready_in = 1'b1;
        for (int k = 0; k < n + 4; k++) begin
            drive_beat(k < n, 'h22, 300 + k);
            #1;
            if (ready_out !== 1'b1) low++;
            @(posedge clk); #1;
            if (action_valid === 1'b1) nv++;
        end
        checks++; if (nv != n || low != 0) begin failures++; $display("FAIL hits_stream got=%0d/%0d exp=%0d/0", nv, low, n); end
    endtask

    task automatic test_counters();
        cfg_entry(2, 'h22, 1'b0, 1'b1, 'hC2);
        run_hits(10);
        read_cnt(5'd2);
        checks++; if (cnt_rd_data !== 32'd10) begin failures++; $display("FAIL hit_cnt10 got=%0d exp=10", cnt_rd_data); end
        checks++; if (sm_cnt_rd_data !== 4'd10) begin failures++; $display("FAIL sm_hit_cnt10 got=%0d exp=10", sm_cnt_rd_data); end
        cfg_entry(2, 'h22, 1'b0, 1'b1, 'hC2);
        read_cnt(5'd2);
        checks++; if (cnt_rd_data !== 32'd0) begin failures++; $display("FAIL hit_cnt_clear got=%0d exp=0", cnt_rd_data); end
        run_hits(20);
        read_cnt(5'd2);
        checks++; if (cnt_rd_data !== 32'd20) begin failures++; $display("FAIL hit_cnt20 got=%0d exp=20", cnt_rd_data); end
        checks++; if (sm_cnt_rd_data !== 4'd15) begin failures++; $display("FAIL sm_hit_sat got=%0d exp=15", sm_cnt_rd_data); end
    endtask

    task automatic test_same_edge();
        ready_in = 1'b1;
        drive_beat(1'b1, 'h5A, 400);
        @(posedge clk); #1;
        drive_beat(1'b1, 'h5A, 401);
        cfg_act_we = 1'b1; cfg_addr = 4'd3; cfg_act = ACT_E3;
        @(posedge clk); #1;
        drive_beat(1'b0, 0, 0);
        cfg_act_we = 1'b0;
        checks++; if (action !== ACT_A3 || phv_out !== mk_phv(400)) begin failures++; $display("FAIL same_edge_old got=%h/%h exp=a3/%h", action, phv_out[31:0], 32'd400); end
        @(posedge clk); #1;
        checks++; if (action !== ACT_E3 || phv_out !== mk_phv(401)) begin failures++; $display("FAIL same_edge_new got=%h/%h exp=e3/%h", action, phv_out[31:0], 32'd401); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        ready_in = 1'b0;
        drive_beat(1'b1, 'h5A, 500);
        @(posedge clk); #1;
        drive_beat(1'b1, 'h5A, 501);
        @(posedge clk); #1;
        drive_beat(1'b0, 0, 0);
        checks++; if (action_valid !== 1'b1 || ready_out !== 1'b0) begin failures++; $display("FAIL rmid_full got=%b/%b exp=1/0", action_valid, ready_out); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (action_valid !== 1'b0 || ready_out !== 1'b0) begin failures++; $display("FAIL rmid_async got=%b/%b exp=0/0", action_valid, ready_out); end
        checks++; if (action !== '0 || phv_out !== '0) begin failures++; $display("FAIL rmid_data got=%h/%h exp=0/0", action, phv_out[31:0]); end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        ready_in = 1'b1;
        read_cnt(5'h10);
        checks++; if (cnt_rd_data !== 32'd0) begin failures++; $display("FAIL rmid_miss0 got=%0d exp=0", cnt_rd_data); end
        beat2('h5A, 502);
        checks++; if (action_valid !== 1'b1 || if_match !== 1'b0 || action !== '0 || match_addr !== '0) begin failures++; $display("FAIL rmid_lookup got=%b/%b/%h/%0d exp=1/0/0/0", action_valid, if_match, action, match_addr); end
        read_cnt(5'd3);
        checks++; if (cnt_rd_data !== 32'd0) begin failures++; $display("FAIL rmid_hit3 got=%0d exp=0", cnt_rd_data); end
        read_cnt(5'h10);
        checks++; if (cnt_rd_data !== 32'd1) begin failures++; $display("FAIL rmid_miss1 got=%0d exp=1", cnt_rd_data); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_stall();
        test_backpressure();
        test_counters();
        test_same_edge();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
